load_completion_queue: RTL

LOAD_COMPLETION_QUEUE -- requirements
Module: load_completion_queue

---
 rtl/load_completion_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/load_completion_queue.sv
// In-order load completion queue: tracks issued loads, extends returning memory data and writes back.
// Define LOAD_EXTEND_EN to enable funct3/offset based lane selection and sign/zero extension.
module load_completion_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_rd,
  input  logic [2:0]       issue_funct3,
  input  logic [1:0]       issue_offset,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [WIDTH-1:0] resp_data,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_index,
  output logic [WIDTH-1:0] wb_data,
  output logic [31:0]      pending_mask,
  output logic             full,
  output logic             empty
);

  localparam int ENTRIES = 1 << DEPTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [4:0]       rd_mem_q  [ENTRIES];
  logic [2:0]       f3_mem_q  [ENTRIES];
  logic [1:0]       off_mem_q [ENTRIES];

  logic [DEPTH-1:0] head_q, head_d;
  logic [DEPTH-1:0] tail_q, tail_d;
  logic [DEPTH:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_index_q, wb_index_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;

  logic             push, accept, pop;
  logic [4:0]       head_rd;
  logic [2:0]       head_f3;
  logic [1:0]       head_off;
  logic [WIDTH-1:0] ext_data;
  logic [DEPTH-1:0] pend_idx;

  assign head_rd  = rd_mem_q[head_q];
  assign head_f3  = f3_mem_q[head_q];
  assign head_off = off_mem_q[head_q];

  assign full        = count_q[DEPTH];
  assign empty       = (count_q == '0);
  assign issue_ready = !full;
  assign resp_ready  = (state_q == WAIT);
  assign wb_valid    = wb_valid_q;
  assign wb_index    = wb_index_q;
  assign wb_data     = wb_data_q;

`ifdef LOAD_EXTEND_EN
  logic [WIDTH-1:0] byte_lane, half_lane;

  always_comb begin
    byte_lane = resp_data >> {head_off, 3'b000};
    half_lane = resp_data >> {head_off[1], 4'b0000};
    case (head_f3)
      3'b000:  ext_data = {{(WIDTH-8){byte_lane[7]}}, byte_lane[7:0]};
      3'b001:  ext_data = {{(WIDTH-16){half_lane[15]}}, half_lane[15:0]};
      3'b100:  ext_data = {{(WIDTH-8){1'b0}}, byte_lane[7:0]};
      3'b101:  ext_data = {{(WIDTH-16){1'b0}}, half_lane[15:0]};
      default: ext_data = resp_data;
    endcase
  end
`else
  logic unused_ext;

  assign unused_ext = ^{head_f3, head_off};
  assign ext_data   = resp_data;
`endif

  // An rd=0 head still visits WB, but with wb_valid low so it pops on its own next cycle.
  always_comb begin
    push       = issue_valid && issue_ready;
    accept     = (state_q == WAIT) && resp_valid;
    pop        = (state_q == WB) && (!wb_valid_q || wb_ready);
    head_d     = pop  ? head_q + 1'b1 : head_q;
    tail_d     = push ? tail_q + 1'b1 : tail_q;
    count_d    = count_q + {{DEPTH{1'b0}}, push} - {{DEPTH{1'b0}}, pop};
    wb_valid_d = wb_valid_q;
    wb_index_d = wb_index_q;
    wb_data_d  = wb_data_q;
    state_d    = state_q;
    if (accept) begin
      wb_valid_d = (head_rd != 5'd0);
      wb_index_d = head_rd;
      wb_data_d  = ext_data;
    end else if (pop) begin
      wb_valid_d = 1'b0;
    end
    case (state_q)
      IDLE:    if (push)       state_d = WAIT;
      WAIT:    if (resp_valid) state_d = WB;
      WB:      if (pop)        state_d = (count_d != '0) ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_mask = '0;
    pend_idx     = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      pend_idx = head_q + DEPTH'(k);
      if ((DEPTH+1)'(k) < count_q) pending_mask[rd_mem_q[pend_idx]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[tail_q]  <= issue_rd;
      f3_mem_q[tail_q]  <= issue_funct3;
      off_mem_q[tail_q] <= issue_offset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      wb_valid_q <= 1'b0;
      wb_index_q <= '0;
      wb_data_q  <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_index_q <= wb_index_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule
